instr_feeder_checker: RTL and testbench



---
 rtl/instr_feeder_checker.sv | 133 +++++++++++++
 tb/tb_instr_feeder_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder_checker.sv
// Memory-side instruction responder and result checker for the accumulator core.
// Optional build macro: FEEDER_STOP_ON_FAIL_EN (end the run on the first mismatch).
module instr_feeder_checker #(
    parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
    input  logic        clk,
    input  logic        CLB,
    input  logic        ld_en,
    input  logic [7:0]  ld_addr,
    input  logic [23:0] ld_data,
    input  logic        start,
    input  logic [7:0]  pc,
    input  logic [7:0]  accum_value,
    output logic [7:0]  input_ins,
    output logic        core_clb,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  pass_count,
    output logic [7:0]  fail_count,
    output logic [7:0]  first_fail_addr
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state_q;
    logic [23:0] mem_q [256];
    logic [7:0]  addr_q;
    logic [15:0] cyc_q;
    logic [7:0]  pass_q;
    logic [7:0]  fail_q;
    logic [7:0]  ffa_q;
    logic        done_q;
    logic        timeout_q;
    logic        core_clb_q;

    logic [23:0] entry;
    logic        halt;
    logic        match;
    logic        stop;
    logic        last;
    logic [7:0]  pass_d;
    logic [7:0]  fail_d;
    logic [15:0] cyc_d;

    assign entry  = mem_q[addr_q];
    assign halt   = (entry[23:16] == 8'hFF);
    assign match  = (entry[15:0] == {accum_value, pc});
    assign pass_d = (match && pass_q != 8'hFF) ? pass_q + 8'd1 : pass_q;
    assign fail_d = (!match && fail_q != 8'hFF) ? fail_q + 8'd1 : fail_q;
    assign cyc_d  = cyc_q + 16'd1;
    assign last   = (cyc_d == MAX_CYCLES);

`ifdef FEEDER_STOP_ON_FAIL_EN
    assign stop = !match;
`else
    assign stop = 1'b0;
`endif

    // Store contents survive reset; only IDLE may write.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && ld_en) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q    <= IDLE;
            addr_q     <= 8'h00;
            cyc_q      <= 16'd0;
            pass_q     <= 8'h00;
            fail_q     <= 8'h00;
            ffa_q      <= 8'h00;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            core_clb_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q    <= RUN;
                        addr_q     <= 8'h00;
                        cyc_q      <= 16'd0;
                        pass_q     <= 8'h00;
                        fail_q     <= 8'h00;
                        ffa_q      <= 8'h00;
                        done_q     <= 1'b0;
                        timeout_q  <= 1'b0;
                        core_clb_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        pass_q <= pass_d;
                        fail_q <= fail_d;
                        if (!match && fail_q == 8'h00) begin
                            ffa_q <= addr_q;
                        end
                        if (stop) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            addr_q <= pc;
                            cyc_q  <= cyc_d;
                            if (last) begin
                                state_q   <= DONE;
                                done_q    <= 1'b1;
                                timeout_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign input_ins       = entry[23:16];
    assign core_clb        = core_clb_q;
    assign done            = done_q;
    assign timeout         = timeout_q;
    assign pass_count      = pass_q;
    assign fail_count      = fail_q;
    assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_instr_feeder_checker.sv
// Randomized bench for instr_feeder_checker against a run-level reference model.
module tb_instr_feeder_checker;
    localparam int MAXC = 300;

    logic        clk = 1'b0;
    logic        CLB = 1'b0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'h00;
    logic [23:0] ld_data = 24'h0;
    logic        start = 1'b0;
    logic [7:0]  pc = 8'h00;
    logic [7:0]  accum_value = 8'h00;
    logic [7:0]  input_ins;
    logic        core_clb;
    logic        done;
    logic        timeout;
    logic [7:0]  pass_count;
    logic [7:0]  fail_count;
    logic [7:0]  first_fail_addr;

    int checks = 0;
    int errors = 0;
    logic [23:0] m  [256];
    logic [15:0] cv [256];

    always #5 clk = ~clk;

    instr_feeder_checker #(.MAX_CYCLES(16'(MAXC))) dut (
        .clk(clk), .CLB(CLB), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start), .pc(pc),
        .accum_value(accum_value), .input_ins(input_ins),
        .core_clb(core_clb), .done(done), .timeout(timeout),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail_addr(first_fail_addr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [23:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en = 1'b0;
        m[a] = d;
    endtask

    task automatic do_reset();
        ld_en = 1'b0;
        start = 1'b0;
        CLB = 1'b0;
        #2;
        CLB = 1'b1;
        step();
    endtask

    task automatic check_reset(input string tag, input bit ins);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_to"}, timeout, 0);
        chk({tag, "_clb"}, core_clb, 0);
        chk({tag, "_pass"}, pass_count, 0);
        chk({tag, "_fail"}, fail_count, 0);
        chk({tag, "_ffa"}, first_fail_addr, 0);
        if (ins) chk({tag, "_ins"}, input_ins, m[0][23:16]);
    endtask

    function automatic logic [23:0] rnd_entry(input int halt_div);
        logic [7:0] op;
        op = 8'($urandom);
        if ($urandom % halt_div == 0) op = 8'hFF;
        else if (op == 8'hFF) op = 8'hFE;
        return {op, 16'($urandom)};
    endfunction

    // Reference: walk the run edge by edge from the store contents and core values.
    task automatic do_run(input int maxe, input bit rnd, input bit ldst);
        logic [15:0] v;
        logic [7:0]  la;
        logic [23:0] ldv;
        int a, p, f, ffa, cyc, post;
        bit fin, to;
        a = 0; p = 0; f = 0; ffa = 0; cyc = 0; post = 0;
        fin = 0; to = 0;
        start = 1'b1;
        if (ldst) begin
            la = 8'($urandom);
            ldv = rnd_entry(4);
            ld_en = 1'b1;
            ld_addr = la;
            ld_data = ldv;
            m[la] = ldv;
        end
        step();
        start = 1'b0;
        ld_en = 1'b0;
        chk("clb_run", core_clb, 1);
        chk("ins_first", input_ins, m[0][23:16]);
        for (int k = 0; k < maxe; k++) begin
            if (rnd) v = ($urandom % 4 != 0) ? m[a][15:0] : 16'($urandom);
            else     v = cv[a];
            {accum_value, pc} = v;
            ld_en = 1'($urandom % 2);
            ld_addr = ($urandom % 2 != 0) ? 8'd2 : 8'($urandom);
            ld_data = 24'($urandom);
            step();
            if (!fin) begin
                if (m[a][23:16] == 8'hFF) begin
                    fin = 1;
                end else begin
                    if (v == m[a][15:0]) begin
                        p = (p < 255) ? p + 1 : 255;
                    end else begin
                        if (f == 0) ffa = a;
                        f = (f < 255) ? f + 1 : 255;
`ifdef FEEDER_STOP_ON_FAIL_EN
                        fin = 1;
`endif
                    end
                    if (!fin) begin
                        a = int'(v[7:0]);
                        cyc++;
                        if (cyc == MAXC) begin
                            fin = 1;
                            to = 1;
                        end
                    end
                end
            end
            chk("ins", input_ins, m[a][23:16]);
            if (fin) post++;
            if (post == 3) break;
        end
        ld_en = 1'b0;
        chk("done", done, 32'(fin));
        chk("timeout", timeout, 32'(to));
        chk("pass", pass_count, p);
        chk("fail", fail_count, f);
        chk("ffa", first_fail_addr, ffa);
        chk("clb_hold", core_clb, 1);
    endtask

    initial begin
        #12;
        check_reset("rst0", 0);
        CLB = 1'b1;
        step();
        for (int i = 0; i < 256; i++) begin
            load(8'(i), rnd_entry(8));
            cv[i] = 16'($urandom);
        end

        load(8'h00, 24'h110000);
        chk("load_fetch", input_ins, 8'h11);

        load(8'h00, 24'h12A101); cv[0] = 16'hA101;
        load(8'h01, 24'h23B202); cv[1] = 16'hB202;
        load(8'h02, 24'h34C303); cv[2] = 16'hC303;
        load(8'h03, 24'hFF0000);
        do_run(10, 0, 0);
        chk("pass_path_pass", pass_count, 3);
        chk("pass_path_fail", fail_count, 0);
        chk("pass_path_done", done, 1);
        do_run(10, 0, 0);
        chk("restart_pass", pass_count, 3);

        do_reset();
        load(8'h01, 24'h23DEAD);
        do_run(10, 0, 0);
        chk("fail_path_fail", fail_count, 1);
        chk("fail_path_ffa", first_fail_addr, 1);
`ifdef FEEDER_STOP_ON_FAIL_EN
        chk("fail_path_pass", pass_count, 1);
`else
        chk("fail_path_pass", pass_count, 2);
`endif

        do_reset();
        load(8'h00, 24'h457700); cv[0] = 16'h7700;
        do_run(MAXC + 5, 0, 0);
        chk("to_flag", timeout, 1);
        chk("to_sat", pass_count, 255);

        do_reset();
        do_run(10, 0, 0);
        CLB = 1'b0;
        #2;
        check_reset("rst_mid", 1);
        CLB = 1'b1;
        step();

        for (int it = 0; it < 25; it++) begin
            do_reset();
            for (int j = 0; j < 8; j++) load(8'($urandom), rnd_entry(6));
            do_run(60, 1, 1'($urandom % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
